// File: rtl/basic_io8_regs.sv
// basic_io8_regs: 6502 page-0x20xx I/O block (switches, buttons, LEDs, 4-digit 7-seg).
// Optional BTN_STICKY_EN: BTN bits latch on rising edge, write-1-to-clear at 0x02.
module basic_io8_regs #(
  parameter int SCAN_BITS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        we,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [15:0] led,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  logic [15:0]     sw_q1, sw_q2;
  logic [4:0]      btn_q1, btn_q2;
  logic [4:0]      btn_rd;
  logic [7:0]      led_lo, led_hi;
  logic [3:0][7:0] disp;
  logic [1:0]      dctl;
  logic [SCAN_BITS-1:0] scan;

  logic wr_led_lo, wr_led_hi, wr_disp, wr_dctl;

  assign wr_led_lo = we && (addr == 8'h10);
  assign wr_led_hi = we && (addr == 8'h11);
  assign wr_disp   = we && (addr[7:2] == 6'b001000);
  assign wr_dctl   = we && (addr == 8'h24);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_q1  <= '0;
      sw_q2  <= '0;
      btn_q1 <= '0;
      btn_q2 <= '0;
    end else begin
      sw_q1  <= sw;
      sw_q2  <= sw_q1;
      btn_q1 <= btn;
      btn_q2 <= btn_q1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_lo <= '0;
      led_hi <= '0;
      disp   <= '0;
      dctl   <= '0;
    end else begin
      if (wr_led_lo) led_lo <= din;
      if (wr_led_hi) led_hi <= din;
      if (wr_disp)   disp[addr[1:0]] <= din;
      if (wr_dctl)   dctl <= din[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scan <= '0;
    else          scan <= scan + SCAN_BITS'(1);
  end

`ifdef BTN_STICKY_EN
  logic [4:0] btn_prev, btn_st, btn_clr;

  assign btn_clr = (we && addr == 8'h02) ? din[4:0] : 5'b0;

  // set wins over clear when both land on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev <= '0;
      btn_st   <= '0;
    end else begin
      btn_prev <= btn_q2;
      btn_st   <= (btn_st & ~btn_clr) | (btn_q2 & ~btn_prev);
    end
  end

  assign btn_rd = btn_st;
`else
  assign btn_rd = btn_q2;
`endif

  assign led = {led_hi, led_lo};

  always_comb begin
    dout = 8'h00;
    case (addr)
      8'h00:   dout = sw_q2[7:0];
      8'h01:   dout = sw_q2[15:8];
      8'h02:   dout = {3'b000, btn_rd};
      8'h10:   dout = led_lo;
      8'h11:   dout = led_hi;
      8'h20:   dout = disp[0];
      8'h21:   dout = disp[1];
      8'h22:   dout = disp[2];
      8'h23:   dout = disp[3];
      8'h24:   dout = {6'b0, dctl};
      default: dout = 8'h00;
    endcase
  end

  logic [1:0] digit;
  logic [7:0] cur;
  logic [6:0] hex7;

  assign digit = scan[SCAN_BITS-1 -: 2];
  assign cur   = disp[digit];

  always_comb begin
    hex7 = 7'h7F;
    case (cur[3:0])
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
      default: hex7 = 7'h7F;
    endcase
  end

  always_comb begin
    an  = 4'b1111;
    seg = 7'h7F;
    dp  = 1'b1;
    if (dctl[0]) begin
      an  = ~(4'b0001 << digit);
      seg = dctl[1] ? ~cur[6:0] : hex7;
      dp  = ~cur[7];
    end
  end

endmodule

// File: tb/tb_basic_io8_regs.sv
// tb_basic_io8_regs: scoreboard bench for basic_io8_regs.
// Build with +define+BTN_STICKY_EN to exercise sticky buttons.
module tb_basic_io8_regs;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        we = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [4:0]  btn = 5'b0;
  logic [15:0] led;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] e;
    string      n;
  } rd_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         lim;
    string      n;
  } dsp_t;

  rd_t  rq[$];
  dsp_t dq[$];

  basic_io8_regs #(.SCAN_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din),
    .dout(dout), .we(we), .sw(sw), .btn(btn), .led(led),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    addr = 8'h00;
  endtask

  task automatic exp_rd(input logic [7:0] a, input logic [7:0] e, input string n);
    rd_t r;
    r.a = a;
    r.e = e;
    r.n = n;
    rq.push_back(r);
  endtask

  task automatic exp_dsp(input logic [3:0] a, input logic [6:0] s, input logic d,
                         input int lim, input string n);
    dsp_t x;
    x.an = a;
    x.seg = s;
    x.dp = d;
    x.lim = lim;
    x.n = n;
    dq.push_back(x);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rd_t r;
    #12;
    checks++;
    if (led !== 16'h0 || an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_outs got led=%h an=%b seg=%b dp=%b exp 0000 1111 1111111 1",
               led, an, seg, dp);
    end
    exp_rd(8'h24, 8'h00, "rst_dctl");
    exp_rd(8'h10, 8'h00, "rst_led_lo");
    exp_rd(8'h20, 8'h00, "rst_disp1");
    while (rq.size() > 0) begin
      r = rq.pop_front();
      addr = r.a;
      #1;
      checks++;
      if (dout !== r.e) begin
        errors++;
        $display("FAIL %s got %h exp %h", r.n, dout, r.e);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_inputs();
    rd_t r;
    @(negedge clk);
    sw  = 16'hA55A;
    btn = 5'b00101;
    @(negedge clk);
    addr = 8'h00;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL sync_lag got %h exp 00", dout);
    end
    wait_clk(2);
    exp_rd(8'h00, 8'h5A, "sw_lo");
    exp_rd(8'h01, 8'hA5, "sw_hi");
    exp_rd(8'h02, 8'h05, "btn");
    while (rq.size() > 0) begin
      r = rq.pop_front();
      @(negedge clk);
      addr = r.a;
      #1;
      checks++;
      if (dout !== r.e) begin
        errors++;
        $display("FAIL %s got %h exp %h", r.n, dout, r.e);
      end
    end
  endtask

  task automatic test_led();
    rd_t r;
    wr(8'h10, 8'h3C);
    checks++;
    if (led !== 16'h003C) begin
      errors++;
      $display("FAIL led_lo_wr got %h exp 003c", led);
    end
    wr(8'h11, 8'hC3);
    checks++;
    if (led !== 16'hC33C) begin
      errors++;
      $display("FAIL led_hi_wr got %h exp c33c", led);
    end
    wr(8'h00, 8'hFF);
    wr(8'h30, 8'hFF);
    exp_rd(8'h10, 8'h3C, "rd_led_lo");
    exp_rd(8'h11, 8'hC3, "rd_led_hi");
    exp_rd(8'h30, 8'h00, "rd_unmapped30");
    exp_rd(8'hFF, 8'h00, "rd_unmappedff");
    exp_rd(8'h00, 8'h5A, "ro_write_ign");
    while (rq.size() > 0) begin
      r = rq.pop_front();
      @(negedge clk);
      addr = r.a;
      #1;
      checks++;
      if (dout !== r.e) begin
        errors++;
        $display("FAIL %s got %h exp %h", r.n, dout, r.e);
      end
    end
  endtask

  task automatic test_display();
    dsp_t x;
    rd_t  r;
    bit   hit;
    wr(8'h20, 8'h01);
    wr(8'h21, 8'h88);
    wr(8'h22, 8'hA5);
    wr(8'h23, 8'h0F);
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL blank_pre_en got an=%b exp 1111", an);
    end
    wr(8'h24, 8'h01);
    exp_dsp(4'b1110, 7'b1111001, 1'b1, 24, "dig0_hex1");
    exp_dsp(4'b1101, 7'b0000000, 1'b0, 6, "dig1_hex8");
    exp_dsp(4'b1011, 7'b0010010, 1'b0, 6, "dig2_hex5");
    exp_dsp(4'b0111, 7'b0001110, 1'b1, 6, "dig3_hexf");
    exp_dsp(4'b1110, 7'b1111001, 1'b1, 6, "dig0_wrap");
    while (dq.size() > 0) begin
      x = dq.pop_front();
      hit = 0;
      for (int i = 0; i < x.lim && !hit; i++) begin
        @(negedge clk);
        if (an === x.an) hit = 1;
      end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL %s an timeout got %b exp %b", x.n, an, x.an);
      end else if (seg !== x.seg || dp !== x.dp) begin
        errors++;
        $display("FAIL %s got seg=%b dp=%b exp seg=%b dp=%b", x.n, seg, dp, x.seg, x.dp);
      end
    end
    exp_rd(8'h24, 8'h01, "rd_dctl");
    exp_rd(8'h23, 8'h0F, "rd_disp4");
    while (rq.size() > 0) begin
      r = rq.pop_front();
      @(negedge clk);
      addr = r.a;
      #1;
      checks++;
      if (dout !== r.e) begin
        errors++;
        $display("FAIL %s got %h exp %h", r.n, dout, r.e);
      end
    end
  endtask

  task automatic test_raw_blank();
    dsp_t x;
    bit   hit;
    bit   bad;
    wr(8'h24, 8'hFF);
    addr = 8'h24;
    #1;
    checks++;
    if (dout !== 8'h03) begin
      errors++;
      $display("FAIL dctl_mask got %h exp 03", dout);
    end
    wr(8'h20, 8'h7F);
    wr(8'h21, 8'h80);
    exp_dsp(4'b1110, 7'h00, 1'b1, 24, "raw_dig0");
    exp_dsp(4'b1101, 7'h7F, 1'b0, 6, "raw_dig1");
    while (dq.size() > 0) begin
      x = dq.pop_front();
      hit = 0;
      for (int i = 0; i < x.lim && !hit; i++) begin
        @(negedge clk);
        if (an === x.an) hit = 1;
      end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL %s an timeout got %b exp %b", x.n, an, x.an);
      end else if (seg !== x.seg || dp !== x.dp) begin
        errors++;
        $display("FAIL %s got seg=%b dp=%b exp seg=%b dp=%b", x.n, seg, dp, x.seg, x.dp);
      end
    end
    wr(8'h24, 8'h00);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL blanking got an=%b seg=%b dp=%b exp 1111 1111111 1", an, seg, dp);
    end
  endtask

  task automatic test_btn();
    rd_t r;
    btn = 5'b0;
    wait_clk(3);
`ifdef BTN_STICKY_EN
    exp_rd(8'h02, 8'h05, "sticky_hold");
    while (rq.size() > 0) begin
      r = rq.pop_front();
      @(negedge clk);
      addr = r.a;
      #1;
      checks++;
      if (dout !== r.e) begin
        errors++;
        $display("FAIL %s got %h exp %h", r.n, dout, r.e);
      end
    end
    wr(8'h02, 8'h05);
    btn[3] = 1'b1;
    wait_clk(5);
    btn[3] = 1'b0;
    wait_clk(3);
    exp_rd(8'h02, 8'h08, "sticky_pulse");
    while (rq.size() > 0) begin
      r = rq.pop_front();
      @(negedge clk);
      addr = r.a;
      #1;
      checks++;
      if (dout !== r.e) begin
        errors++;
        $display("FAIL %s got %h exp %h", r.n, dout, r.e);
      end
    end
    wr(8'h02, 8'h01);
    addr = 8'h02;
    #1;
    checks++;
    if (dout !== 8'h08) begin
      errors++;
      $display("FAIL w1c_other got %h exp 08", dout);
    end
    wr(8'h02, 8'h08);
    addr = 8'h02;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL w1c got %h exp 00", dout);
    end
    btn[1] = 1'b1;
    @(negedge clk);
    wr(8'h02, 8'h02);
    addr = 8'h02;
    #1;
    checks++;
    if (dout !== 8'h02) begin
      errors++;
      $display("FAIL set_beats_clr got %h exp 02", dout);
    end
    wr(8'h02, 8'h02);
    addr = 8'h02;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL clr_held got %h exp 00", dout);
    end
    btn[1] = 1'b0;
`else
    exp_rd(8'h02, 8'h00, "btn_live_rel");
    while (rq.size() > 0) begin
      r = rq.pop_front();
      @(negedge clk);
      addr = r.a;
      #1;
      checks++;
      if (dout !== r.e) begin
        errors++;
        $display("FAIL %s got %h exp %h", r.n, dout, r.e);
      end
    end
    btn[3] = 1'b1;
    wait_clk(3);
    wr(8'h02, 8'hFF);
    addr = 8'h02;
    #1;
    checks++;
    if (dout !== 8'h08) begin
      errors++;
      $display("FAIL btn_wr_ign got %h exp 08", dout);
    end
    btn[3] = 1'b0;
    wait_clk(3);
    addr = 8'h02;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL btn_live got %h exp 00", dout);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    rd_t r;
    wr(8'h24, 8'h01);
    @(negedge clk);
    addr = 8'h10;
    din  = 8'hFF;
    we   = 1'b1;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (led !== 16'h0 || an !== 4'b1111) begin
      errors++;
      $display("FAIL mid_write_rst got led=%h an=%b exp 0000 1111", led, an);
    end
    @(negedge clk);
    we = 1'b0;
    reset_n = 1'b1;
    exp_rd(8'h10, 8'h00, "mw_led_lo");
    exp_rd(8'h11, 8'h00, "mw_led_hi");
    exp_rd(8'h21, 8'h00, "mw_disp2");
    exp_rd(8'h24, 8'h00, "mw_dctl");
    while (rq.size() > 0) begin
      r = rq.pop_front();
      @(negedge clk);
      addr = r.a;
      #1;
      checks++;
      if (dout !== r.e) begin
        errors++;
        $display("FAIL %s got %h exp %h", r.n, dout, r.e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_inputs();
    test_led();
    test_display();
    test_raw_blank();
    test_btn();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
